// File: rtl/button_pkg.sv
// Shared types and default timing for the debounced-button gesture logic.
package button_pkg;

    typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG_HELD} press_state_t;

    localparam int unsigned LONG_CYCLES_DEF = 50_000_000;
    localparam int unsigned GAP_CYCLES_DEF  = 25_000_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_press_classifier.sv
// Classifies debounced button activity into short, double and long presses,
// emitting one registered single-cycle pulse per gesture.
module button_press_classifier
    import button_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
    parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic db_level,
    input  logic db_tick,
    output logic short_tick,
    output logic double_tick,
    output logic long_tick,
    output logic busy
);

    localparam int unsigned CNT_MAX = max_u(LONG_CYCLES, GAP_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    press_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (db_tick) state_d = PRESS1;
            end
            PRESS1: begin
                if (!db_level)                state_d = WAIT2;
                else if (cnt_q == LONG_LAST)  state_d = LONG_HELD;
            end
            WAIT2: begin
                // A tick on the last gap cycle still counts as a double press.
                if (db_tick)                  state_d = PRESS2;
                else if (cnt_q == GAP_LAST)   state_d = IDLE;
            end
            PRESS2, LONG_HELD: begin
                if (!db_level) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Exits above bound cnt below CNT_MAX, so it never wraps.
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == PRESS1 || state_q == WAIT2) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        short_d  = (state_q == WAIT2) && !db_tick && (cnt_q == GAP_LAST);
        double_d = (state_q == WAIT2) && db_tick;
        long_d   = (state_q == PRESS1) && db_level && (cnt_q == LONG_LAST);
        busy_d   = (state_d != IDLE);
    end

    assign short_tick  = short_q;
    assign double_tick = double_q;
    assign long_tick   = long_q;
    assign busy        = busy_q;

endmodule
